hpf_nibble_tx: RTL and testbench

//  Transmit side of the HPF nibble-serial sample link. Accepts 8-bit signed samples from an

---
 rtl/hpf_pkg.sv | 8 +
 rtl/hpf_tx_fifo.sv | 40 ++++
 rtl/hpf_nibble_tx.sv | 70 +++++++
 tb/tb_hpf_nibble_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hpf_pkg.sv
// hpf_pkg: constants shared by the HPF nibble link transmitter, the HPF core and its bench
package hpf_pkg;
  localparam int FRAME_LEN_DEF = 20;
  localparam int SLOT_LO       = 0;
  localparam int SLOT_HI       = 1;
  localparam int NIB_W         = 4;
  localparam int SAMP_W        = 8;
endpackage

// File: rtl/hpf_tx_fifo.sv
// hpf_tx_fifo: synchronous sample FIFO with occupancy count, asynchronous active-high reset
module hpf_tx_fifo
  import hpf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SAMP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (push) r_wr <= r_wr + 1'b1;
      if (pop) r_rd <= r_rd + 1'b1;
      r_level <= r_level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (push) r_mem[r_wr] <= din;
  assign dout  = r_mem[r_rd];
  assign level = r_level;
  assign full  = r_level == LW'(DEPTH);
  assign empty = r_level == '0;
endmodule

// File: rtl/hpf_nibble_tx.sv
// hpf_nibble_tx: buffers signed samples and sends low/high nibble in slots 0/1 of each frame
// HPF_TX_RESYNC_EN adds sync_in, which forces the next edge into slot 0.
module hpf_nibble_tx
  import hpf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_LEN  = FRAME_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SAMP_W-1:0]             s_data,
  input  logic                          s_valid,
`ifdef HPF_TX_RESYNC_EN
  input  logic                          sync_in,
`endif
  output logic                          s_ready,
  output logic [NIB_W-1:0]              x_half,
  output logic                          frame_start,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int SW = $clog2(FRAME_LEN);
  logic [SW-1:0]     r_slot;
  logic [SAMP_W-1:0] r_hold;
  logic [SW-1:0]     w_next;
  logic [SAMP_W-1:0] w_dout;
  logic              w_sync;
  logic              w_wrap;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
`ifdef HPF_TX_RESYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif
  assign w_wrap  = w_sync || r_slot == SW'(FRAME_LEN - 1);
  assign w_next  = w_wrap ? SW'(SLOT_LO) : r_slot + 1'b1;
  assign w_pop   = w_wrap && !w_empty;
  assign s_ready = !reset && !w_full;
  assign w_push  = s_valid && s_ready;
  hpf_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(SAMP_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (s_data),
    .dout  (w_dout),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );
  // an empty FIFO at slot 0 sends a zero sample rather than stalling the core
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_slot      <= SW'(FRAME_LEN - 1);
      r_hold      <= '0;
      x_half      <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      r_slot      <= w_next;
      frame_start <= w_wrap;
      underrun    <= w_wrap && w_empty;
      x_half      <= w_wrap ? (w_empty ? '0 : w_dout[NIB_W-1:0])
                   : (w_next == SW'(SLOT_HI) ? r_hold[SAMP_W-1:NIB_W] : '0);
      if (w_wrap) r_hold <= w_empty ? '0 : w_dout;
    end
endmodule

// File: tb/tb_hpf_nibble_tx.sv
// tb_hpf_nibble_tx: queue-based frame model compared every cycle, plus directed literal checks
module tb_hpf_nibble_tx;
  localparam int DEPTH = 4;
  localparam int FLEN  = 20;
  logic       clk = 0;
  logic       reset = 1;
  logic [7:0] s_data = 0;
  logic       s_valid = 0;
  logic       s_ready;
  logic [3:0] x_half;
  logic       frame_start;
  logic       underrun;
  logic [2:0] fifo_level;
  int checks = 0;
  int failures = 0;
  logic chk_en = 0;
`ifdef HPF_TX_RESYNC_EN
  logic sync_in = 0;
`endif
  hpf_nibble_tx #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
`ifdef HPF_TX_RESYNC_EN
    .sync_in     (sync_in),
`endif
    .s_ready     (s_ready),
    .x_half      (x_half),
    .frame_start (frame_start),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  // model: frame position counted from reset release (or resync), samples held in a queue
  logic [7:0] q[$];
  int         m_t = 0;
  int         m_slot = FLEN - 1;
  logic [7:0] m_hold = 0;
  logic [3:0] m_x = 0;
  logic       m_fs = 0;
  logic       m_ur = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_t = 0; m_slot = FLEN - 1; m_hold = 0; m_x = 0; m_fs = 0; m_ur = 0;
    end else begin
      logic rdy, pv;
      logic [7:0] pd;
      rdy = q.size() < DEPTH;
      pv = s_valid;
      pd = s_data;
`ifdef HPF_TX_RESYNC_EN
      if (sync_in) m_t = 0;
`endif
      m_slot = m_t % FLEN;
      m_t++;
      m_fs = m_slot == 0; m_ur = 0; m_x = 0;
      if (m_slot == 0) begin
        if (q.size() > 0) begin
          m_hold = q.pop_front();
          m_x = m_hold[3:0];
        end else begin
          m_hold = 0;
          m_ur = 1;
        end
      end else if (m_slot == 1) m_x = m_hold[7:4];
      if (pv && rdy) q.push_back(pd);
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("x_half", x_half, m_x);
    chk("frame_start", frame_start, m_fs);
    chk("underrun", underrun, m_ur);
    chk("fifo_level", fifo_level, q.size());
    chk("s_ready", s_ready, !reset && q.size() < DEPTH);
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic to_slot(input int k);
    int b;
    b = 0;
    while (m_slot != k) begin
      step(1);
      b++;
      if (b > 45) begin chk("to_slot_timeout", 1, 0); break; end
    end
  endtask
  task automatic push_wait(input logic [7:0] d);
    logic acc;
    int b;
    b = 0;
    s_data = d;
    s_valid = 1;
    do begin
      acc = s_ready;
      step(1);
      b++;
      if (b > 60) begin chk("push_timeout", 1, 0); break; end
    end while (!acc);
    s_valid = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    chk("rst_x_half", x_half, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", s_ready, 0);
    chk_en = 1;
    @(negedge clk); @(negedge clk);
    reset = 0;
    // idle link: three underrun frames, zero nibbles
    step(1);
    chk("t1_fs0", frame_start, 1); chk("t1_ur0", underrun, 1); chk("t1_x0", x_half, 0);
    step(20);
    chk("t1_fs20", frame_start, 1); chk("t1_ur20", underrun, 1);
    step(20);
    chk("t1_fs40", frame_start, 1); chk("t1_ur40", underrun, 1);
    // five back-to-back samples into a 4-deep buffer
    to_slot(2);
    for (int i = 0; i < 5; i++) begin
      push_wait(8'h11 * (i + 1));
      if (i == 3) begin
        chk("t3_ready_full", s_ready, 0);
        chk("t3_level_full", fifo_level, 4);
      end
    end
    chk("t3_slot_after5", m_slot, 1);
    to_slot(0);
    chk("t3_x22lo", x_half, 4'h2);
    step(1);
    chk("t3_x22hi", x_half, 4'h2);
    step(5 * FLEN);
    chk("t3_drained", fifo_level, 0);
    // sample arriving on the edge into slot 0 of an empty buffer waits a frame
    to_slot(19);
    s_data = 8'h3C; s_valid = 1;
    step(1);
    s_valid = 0;
    chk("t4_ur", underrun, 1); chk("t4_x0", x_half, 0); chk("t4_lvl", fifo_level, 1);
    step(1);
    chk("t4_x1", x_half, 0);
    to_slot(0);
    chk("t4_xC", x_half, 4'hC); chk("t4_ur_n", underrun, 0);
    step(1);
    chk("t4_x3", x_half, 4'h3);
    // reset in slot 1 with three samples left queued
    to_slot(2);
    for (int i = 0; i < 4; i++) push_wait(8'h70 + 8'(i));
    to_slot(1);
    chk("t5_lvl3", fifo_level, 3);
    reset = 1;
    #1;
    chk("t5_lvl0", fifo_level, 0); chk("t5_x0", x_half, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    step(1);
    chk("t5_ur", underrun, 1); chk("t5_fs", frame_start, 1);
    // first post-release frame carries a new sample to the next frame
    to_slot(4);
    push_wait(8'hA5);
    to_slot(0);
    chk("t2_x5", x_half, 4'h5); chk("t2_ur", underrun, 0);
    step(1);
    chk("t2_xA", x_half, 4'hA); chk("t2_fs1", frame_start, 0);
    step(1);
    chk("t2_xidle", x_half, 0);
`ifdef HPF_TX_RESYNC_EN
    to_slot(2);
    push_wait(8'h96);
    to_slot(7);
    sync_in = 1;
    step(1);
    sync_in = 0;
    chk("t6_fs", frame_start, 1); chk("t6_x6", x_half, 4'h6); chk("t6_ur", underrun, 0);
    step(1);
    chk("t6_x9", x_half, 4'h9);
    step(19);
    chk("t6_fs20", frame_start, 1);
`endif
    step(3);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
